// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX->MEM bus, completes loads from the data SRAM and drives the WB and forwarding buses.
// Build option: define MEM_ALIGN_CHECK_EN to flag misaligned halfword/word loads on excp_ale.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 81,
    parameter int MEM_TO_WB_WD = 70,
    parameter int FWD_WD       = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_data_ok,
    output logic                    stallreq,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [FWD_WD-1:0]       mem_to_id_bus,
    output logic                    excp_ale,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HELD = 2'd2} state_t;

    state_t                  state;
    logic [EX_TO_MEM_WD-1:0] r;
    logic [31:0]             rdata_buf;

    logic [4:0]  mem_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = r;

    logic is_load;
    logic is_load_eff;
    assign is_load = data_ram_en & (data_ram_wen == 4'd0) & (mem_op != 5'd0);

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned  = ((mem_op[2] | mem_op[1]) & ex_result[0]) | (mem_op[0] & (ex_result[1:0] != 2'd0));
    assign excp_ale    = is_load & misaligned;
    assign is_load_eff = is_load & ~misaligned;
`else
    assign excp_ale    = 1'b0;
    assign is_load_eff = is_load;
`endif

    // Handshake: data_sram_data_ok is a one-cycle valid for data_sram_rdata with no ready back;
    // MEM cannot refuse data, so a stalled pipeline parks it in rdata_buf (HELD) until stall[3] drops.
    assign stallreq  = is_load_eff & ~data_sram_data_ok & (state != HELD);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (!stall[3]) begin
            r <= ex_to_mem_bus;
        end else if (!stall[4]) begin
            r <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdata_buf <= 32'd0;
        end else if (!stall[3]) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_load_eff && !data_sram_data_ok) begin
                        state <= WAIT;
                    end else if (is_load_eff && data_sram_data_ok) begin
                        rdata_buf <= data_sram_rdata;
                        state     <= HELD;
                    end
                end
                WAIT: begin
                    if (data_sram_data_ok) begin
                        rdata_buf <= data_sram_rdata;
                        state     <= HELD;
                    end
                end
                HELD:    state <= HELD;
                default: state <= IDLE;
            endcase
        end
    end

    logic [31:0] raw;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    assign raw = data_sram_data_ok ? data_sram_rdata : rdata_buf;

    always_comb begin
        byte_v    = raw[{ex_result[1:0], 3'b000} +: 8];
        half_v    = ex_result[1] ? raw[31:16] : raw[15:0];
        load_data = raw;
        if (mem_op[4])      load_data = {{24{byte_v[7]}}, byte_v};
        else if (mem_op[3]) load_data = {24'd0, byte_v};
        else if (mem_op[2]) load_data = {{16{half_v[15]}}, half_v};
        else if (mem_op[1]) load_data = {16'd0, half_v};
    end

    logic [31:0] rf_wdata;
    logic        rf_we_out;
    assign rf_wdata  = sel_rf_res ? load_data : ex_result;
    // Suppressing the write while the load is outstanding keeps ID from forwarding stale data.
    assign rf_we_out = rf_we & ~stallreq & ~excp_ale;

    assign mem_to_wb_bus = {pc, rf_we_out, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we_out, rf_waddr, rf_wdata};

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load alignment, delayed data_ok, downstream hold, bubble and
// the MEM_ALIGN_CHECK_EN misaligned-load behaviour.
module tb_mem_stage;

    localparam int EX_TO_MEM_WD = 81;
    localparam int MEM_TO_WB_WD = 70;
    localparam int FWD_WD       = 38;

    logic                    clk;
    logic                    rst;
    logic [5:0]              stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic                    data_sram_data_ok;
    logic                    stallreq;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [FWD_WD-1:0]       mem_to_id_bus;
    logic                    excp_ale;
    logic [1:0]              state_dbg;

    logic ext_stop;
    logic bubble;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    mem_stage #(
        .EX_TO_MEM_WD(EX_TO_MEM_WD),
        .MEM_TO_WB_WD(MEM_TO_WB_WD),
        .FWD_WD(FWD_WD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .ex_to_mem_bus(ex_to_mem_bus),
        .data_sram_rdata(data_sram_rdata),
        .data_sram_data_ok(data_sram_data_ok),
        .stallreq(stallreq),
        .mem_to_wb_bus(mem_to_wb_bus),
        .mem_to_id_bus(mem_to_id_bus),
        .excp_ale(excp_ale),
        .state_dbg(state_dbg)
    );

    // Stall controller model: MEM request or external stop freezes through WB; bubble stops only up to MEM.
    assign stall = bubble ? 6'b001111 : ((stallreq | ext_stop) ? 6'b011111 : 6'b000000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] pc, input logic en,
                                       input logic [3:0] wen, input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {op, pc, en, wen, sel, we, wa, res};
    endfunction

    task automatic issue(input logic [80:0] bus);
        ex_to_mem_bus = bus;
        tick();
        ex_to_mem_bus = '0;
    endtask

    localparam logic [4:0] OP_LB = 5'b10000, OP_LBU = 5'b01000, OP_LH = 5'b00100,
                           OP_LHU = 5'b00010, OP_LW = 5'b00001;

    logic [4:0]  tbl_op   [7];
    logic [31:0] tbl_addr [7];
    logic [31:0] tbl_exp  [7];

    initial begin
        rst = 1'b1;
        ext_stop = 1'b0;
        bubble = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = $urandom_range(0, 32'hFFFF);
        ex_to_mem_bus = mk(OP_LW, 32'h10, 1'b1, 4'd0, 1'b1, 1'b1, 5'd1, 32'h0);

        // Reset with data_ok high
        tick();
        tick();
        @(negedge clk);
        check("rst_stallreq", {69'd0, stallreq}, 70'd0);
        check("rst_wb", mem_to_wb_bus, 70'd0);
        check("rst_id", {32'd0, mem_to_id_bus}, 70'd0);
        check("rst_state", {68'd0, state_dbg}, 70'd0);
        check("rst_ale", {69'd0, excp_ale}, 70'd0);
        rst = 1'b0;
        data_sram_data_ok = 1'b0;
        ex_to_mem_bus = '0;
        tick();

        // lw with data_ok in the load cycle: no stall
        issue(mk(OP_LW, 32'h1000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd5, 32'h100));
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h89ABCDEF;
        @(negedge clk);
        check("lw_stallreq", {69'd0, stallreq}, 70'd0);
        check("lw_wb", mem_to_wb_bus, {32'h1000, 1'b1, 5'd5, 32'h89ABCDEF});
        tick();
        data_sram_data_ok = 1'b0;

        // Byte/half extraction table against rdata 0x80FF7F01
        tbl_op[0] = OP_LB;  tbl_addr[0] = 32'h103; tbl_exp[0] = 32'hFFFFFF80;
        tbl_op[1] = OP_LBU; tbl_addr[1] = 32'h103; tbl_exp[1] = 32'h00000080;
        tbl_op[2] = OP_LH;  tbl_addr[2] = 32'h102; tbl_exp[2] = 32'hFFFF80FF;
        tbl_op[3] = OP_LHU; tbl_addr[3] = 32'h102; tbl_exp[3] = 32'h000080FF;
        tbl_op[4] = OP_LB;  tbl_addr[4] = 32'h101; tbl_exp[4] = 32'h0000007F;
        tbl_op[5] = OP_LH;  tbl_addr[5] = 32'h100; tbl_exp[5] = 32'h00007F01;
        tbl_op[6] = OP_LB;  tbl_addr[6] = 32'h102; tbl_exp[6] = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) begin
            issue(mk(tbl_op[i], 32'h1100, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, tbl_addr[i]));
            data_sram_data_ok = 1'b1;
            data_sram_rdata = 32'h80FF7F01;
            exp_q.push_back(tbl_exp[i]);
            @(negedge clk);
            check("ld_tbl", {32'd0, mem_to_id_bus}, {32'd0, 1'b1, 5'd3, exp_q.pop_front()});
            tick();
            data_sram_data_ok = 1'b0;
        end

        // lw with data_ok three cycles late
        issue(mk(OP_LW, 32'h2000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd7, 32'h104));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dly_stallreq", {69'd0, stallreq}, 70'd1);
            check("dly_id_we", {69'd0, mem_to_id_bus[37]}, 70'd0);
            if (i == 1) check("dly_state_wait", {68'd0, state_dbg}, 70'd1);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h12345678;
        @(negedge clk);
        check("dly_stall_done", {69'd0, stallreq}, 70'd0);
        check("dly_wb", mem_to_wb_bus, {32'h2000, 1'b1, 5'd7, 32'h12345678});
        tick();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("dly_state_idle", {68'd0, state_dbg}, 70'd0);
        tick();

        // data_ok under a downstream hold of two cycles -> HELD
        issue(mk(OP_LW, 32'h3000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h200));
        ext_stop = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("hold_wb0", mem_to_wb_bus, {32'h3000, 1'b1, 5'd9, 32'hCAFEF00D});
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("hold_state", {68'd0, state_dbg}, 70'd2);
        check("hold_stallreq", {69'd0, stallreq}, 70'd0);
        check("hold_wb1", mem_to_wb_bus, {32'h3000, 1'b1, 5'd9, 32'hCAFEF00D});
        tick();
        ext_stop = 1'b0;
        @(negedge clk);
        check("hold_wb2", mem_to_wb_bus, {32'h3000, 1'b1, 5'd9, 32'hCAFEF00D});
        tick();
        @(negedge clk);
        check("hold_release_state", {68'd0, state_dbg}, 70'd0);
        check("hold_release_wb", mem_to_wb_bus, 70'd0);

        // Store passes through; stray data_ok ignored; bubble clears the register
        issue(mk(5'd0, 32'h4000, 1'b1, 4'hF, 1'b0, 1'b1, 5'd10, 32'h55));
        data_sram_data_ok = 1'b1;
        ext_stop = 1'b1;
        @(negedge clk);
        check("st_stallreq", {69'd0, stallreq}, 70'd0);
        check("st_wb", mem_to_wb_bus, {32'h4000, 1'b1, 5'd10, 32'h55});
        tick();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("st_state_idle", {68'd0, state_dbg}, 70'd0);
        ext_stop = 1'b0;
        bubble = 1'b1;
        tick();
        bubble = 1'b0;
        @(negedge clk);
        check("bubble_wb", mem_to_wb_bus, 70'd0);
        tick();

        // Reset in the middle of WAIT
        issue(mk(OP_LW, 32'h5000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd12, 32'h300));
        tick();
        @(negedge clk);
        check("rstw_state_wait", {68'd0, state_dbg}, 70'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstw_state", {68'd0, state_dbg}, 70'd0);
        check("rstw_stallreq", {69'd0, stallreq}, 70'd0);
        check("rstw_wb", mem_to_wb_bus, 70'd0);
        tick();

        // Misaligned lw at 0x102
        issue(mk(OP_LW, 32'h6000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd11, 32'h102));
`ifdef MEM_ALIGN_CHECK_EN
        ext_stop = 1'b1;
        @(negedge clk);
        check("ale_flag", {69'd0, excp_ale}, 70'd1);
        check("ale_stallreq", {69'd0, stallreq}, 70'd0);
        check("ale_id_we", {69'd0, mem_to_id_bus[37]}, 70'd0);
        check("ale_wb_we", {69'd0, mem_to_wb_bus[37]}, 70'd0);
        tick();
        @(negedge clk);
        check("ale_state", {68'd0, state_dbg}, 70'd0);
        ext_stop = 1'b0;
        tick();
`else
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h11223344;
        @(negedge clk);
        check("ale_flag", {69'd0, excp_ale}, 70'd0);
        check("ale_wb", mem_to_wb_bus, {32'h6000, 1'b1, 5'd11, 32'h11223344});
        tick();
        data_sram_data_ok = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
